vend_credit_ctrl: RTL and testbench

Parametrised successor to the team's fixed 25/50-cent vending FSM. It accumulates coin credit in price units and requests a vend once credit reaches PRICE. After the vend it returns any excess credit as change, one unit at a time. A cancel refunds all held credit. It sits between the coin acceptor front-end and the dispenser/change-hopper drivers, with req/ack handshakes on both outputs.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_coin_decode.sv | 16 +
 rtl/vend_credit_ctrl.sv | 107 ++++++++++
 tb/tb_vend_credit_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller family.
// Coin codes, their unit values and the controller state encoding live here.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        RETURN = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_QTR    = 2'b01;
    localparam logic [1:0] COIN_HALF   = 2'b10;
    localparam logic [1:0] COIN_DOLLAR = 2'b11;

    localparam logic [2:0] UNITS_NONE   = 3'd0;
    localparam logic [2:0] UNITS_QTR    = 3'd1;
    localparam logic [2:0] UNITS_HALF   = 3'd2;
    localparam logic [2:0] UNITS_DOLLAR = 3'd4;

    function automatic logic [2:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_QTR:    return UNITS_QTR;
            COIN_HALF:   return UNITS_HALF;
            COIN_DOLLAR: return UNITS_DOLLAR;
            default:     return UNITS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin code to unit value decoder; valid flags a real coin.
// Kept standalone so the note acceptor front-end can share it.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic [1:0] coin,
    output logic [2:0] units,
    output logic       valid
);

    always_comb begin
        units = coin_units(coin);
        valid = (coin != COIN_NONE);
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Parametrised vending credit controller: accumulates coin credit, requests a
// vend at PRICE, then pays back any excess one unit at a time.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                sold_out,
    output logic                dispense_req,
    input  logic                dispense_ack,
    output logic                change_req,
    input  logic                change_ack,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    vend_state_t         state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic                reject_q, reject_nxt;
    logic [2:0]          units;
    logic                units_valid;
    logic                coin_in;
    logic [CREDIT_W:0]   newc;

    vend_coin_decode u_coin_decode (
        .coin  (coin),
        .units (units),
        .valid (units_valid)
    );

    // One extra bit so the overflow compare against MAX_CREDIT cannot wrap.
    assign newc    = {1'b0, credit_q} + (CREDIT_W+1)'(units);
    assign coin_in = coin_valid && units_valid;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_q;
        reject_nxt = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (cancel) begin
                    reject_nxt = coin_in;
                    if (state == ACCUM) state_nxt = RETURN;
                end else if (coin_in) begin
                    if (newc > MAX_X) begin
                        reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = newc[CREDIT_W-1:0];
                        state_nxt  = (newc >= PRICE_X && !sold_out) ? VEND : ACCUM;
                    end
                end else if (state == ACCUM && {1'b0, credit_q} >= PRICE_X && !sold_out) begin
                    state_nxt = VEND;
                end
            end
            VEND: begin
                reject_nxt = coin_in;
                if (dispense_ack) begin
                    credit_nxt = credit_q - PRICE_C;
                    state_nxt  = (credit_q == PRICE_C) ? IDLE : RETURN;
                end
            end
            RETURN: begin
                reject_nxt = coin_in;
                if (change_ack) begin
                    credit_nxt = credit_q - ONE_C;
                    if (credit_q == ONE_C) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit_q <= credit_nxt;
            reject_q <= reject_nxt;
        end
    end

    assign dispense_req = (state == VEND);
    assign change_req   = (state == RETURN);
    assign busy         = (state == VEND) || (state == RETURN);
    assign coin_reject  = reject_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: each cycle's expected outputs are
// queued with the stimulus and compared against the sampled DUT outputs.
module tb_vend_credit_ctrl;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = COIN_NONE;
    logic       cancel = 1'b0;
    logic       sold_out = 1'b0;
    logic       dispense_ack = 1'b0;
    logic       change_ack = 1'b0;
    logic       dispense_req, change_req, coin_reject, busy;
    logic [3:0] credit;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    vend_credit_ctrl #(
        .CREDIT_W   (4),
        .PRICE      (3),
        .MAX_CREDIT (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .cancel       (cancel),
        .sold_out     (sold_out),
        .dispense_req (dispense_req),
        .dispense_ack (dispense_ack),
        .change_req   (change_req),
        .change_ack   (change_ack),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    // Packed expectation: {credit, dispense_req, change_req, coin_reject, busy}
    function automatic logic [7:0] E(input int c, input bit d, input bit r, input bit j, input bit b);
        return {4'(c), d, r, j, b};
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, sample DUT.
    task automatic apply(input string tag, input logic rst, input logic cv, input logic [1:0] cn,
                         input logic can, input logic so, input logic da, input logic ca,
                         input logic [7:0] expv);
        reset = rst; coin_valid = cv; coin = cn; cancel = can;
        sold_out = so; dispense_ack = da; change_ack = ca;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs_q.push_back({credit, dispense_req, change_req, coin_reject, busy});
    endtask

    task automatic test_reset();
        logic [7:0] e, o; string t;
        apply("reset_with_coin", 1, 1, COIN_DOLLAR, 0, 0, 0, 0, E(0,0,0,0,0));
        apply("reset_idle",      1, 0, COIN_NONE,   0, 0, 1, 1, E(0,0,0,0,0));
        apply("after_reset",     0, 0, COIN_NONE,   0, 0, 0, 0, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_idle_ignores();
        logic [7:0] e, o; string t;
        apply("coin_none",     0, 1, COIN_NONE, 0, 0, 0, 0, E(0,0,0,0,0));
        apply("cancel_idle",   0, 0, COIN_NONE, 1, 0, 0, 0, E(0,0,0,0,0));
        apply("acks_idle",     0, 0, COIN_NONE, 0, 0, 1, 1, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_quarters();
        logic [7:0] e, o; string t;
        apply("qtr1",       0, 1, COIN_QTR,  0, 0, 0, 0, E(1,0,0,0,0));
        apply("qtr2",       0, 1, COIN_QTR,  0, 0, 0, 0, E(2,0,0,0,0));
        apply("qtr3_vend",  0, 1, COIN_QTR,  0, 0, 0, 0, E(3,1,0,0,1));
        apply("vend_hold",  0, 0, COIN_NONE, 0, 0, 0, 0, E(3,1,0,0,1));
        apply("vend_ack",   0, 0, COIN_NONE, 0, 0, 1, 0, E(0,0,0,0,0));
        apply("no_change",  0, 0, COIN_NONE, 0, 0, 0, 0, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, o; string t;
        apply("half",        0, 1, COIN_HALF,   0, 0, 0, 0, E(2,0,0,0,0));
        apply("dollar_vend", 0, 1, COIN_DOLLAR, 0, 0, 0, 0, E(6,1,0,0,1));
        apply("ack_return",  0, 0, COIN_NONE,   0, 0, 1, 0, E(3,0,1,0,1));
        apply("chg_2",       0, 0, COIN_NONE,   0, 0, 0, 1, E(2,0,1,0,1));
        apply("chg_1",       0, 0, COIN_NONE,   0, 0, 0, 1, E(1,0,1,0,1));
        apply("chg_0",       0, 0, COIN_NONE,   0, 0, 0, 1, E(0,0,0,0,0));
        apply("post_idle",   0, 0, COIN_NONE,   0, 0, 0, 0, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_sold_out_overflow();
        logic [7:0] e, o; string t;
        apply("so_dollar",     0, 1, COIN_DOLLAR, 0, 1, 0, 0, E(4,0,0,0,0));
        apply("so_half",       0, 1, COIN_HALF,   0, 1, 0, 0, E(6,0,0,0,0));
        apply("so_overflow",   0, 1, COIN_HALF,   0, 1, 0, 0, E(6,0,0,1,0));
        apply("so_fill_max",   0, 1, COIN_QTR,    0, 1, 0, 0, E(7,0,0,0,0));
        apply("so_over_max",   0, 1, COIN_QTR,    0, 1, 0, 0, E(7,0,0,1,0));
        apply("so_release",    0, 0, COIN_NONE,   0, 0, 0, 0, E(7,1,0,0,1));
        apply("so_ack",        0, 0, COIN_NONE,   0, 0, 1, 0, E(4,0,1,0,1));
        apply("so_chg3",       0, 0, COIN_NONE,   0, 0, 0, 1, E(3,0,1,0,1));
        apply("so_chg2",       0, 0, COIN_NONE,   0, 0, 0, 1, E(2,0,1,0,1));
        apply("so_chg1",       0, 0, COIN_NONE,   0, 0, 0, 1, E(1,0,1,0,1));
        apply("so_chg0",       0, 0, COIN_NONE,   0, 0, 0, 1, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_cancel();
        logic [7:0] e, o; string t;
        apply("cx_half",       0, 1, COIN_HALF, 0, 0, 0, 0, E(2,0,0,0,0));
        apply("cx_cancel_qtr", 0, 1, COIN_QTR,  1, 0, 0, 0, E(2,0,1,1,1));
        apply("cx_chg1",       0, 0, COIN_NONE, 0, 0, 0, 1, E(1,0,1,0,1));
        apply("cx_chg0",       0, 0, COIN_NONE, 0, 0, 0, 1, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_busy_ignores();
        logic [7:0] e, o; string t;
        apply("bz_dollar",     0, 1, COIN_DOLLAR, 0, 0, 0, 0, E(4,1,0,0,1));
        apply("bz_qtr_vend",   0, 1, COIN_QTR,    0, 0, 0, 0, E(4,1,0,1,1));
        apply("bz_chg_vend",   0, 0, COIN_NONE,   0, 0, 0, 1, E(4,1,0,0,1));
        apply("bz_cx_vend",    0, 0, COIN_NONE,   1, 0, 0, 0, E(4,1,0,0,1));
        apply("bz_ack",        0, 0, COIN_NONE,   0, 0, 1, 0, E(1,0,1,0,1));
        apply("bz_dack_ret",   0, 0, COIN_NONE,   0, 0, 1, 0, E(1,0,1,0,1));
        apply("bz_qtr_ret",    0, 1, COIN_QTR,    0, 0, 0, 0, E(1,0,1,1,1));
        apply("bz_chg0",       0, 0, COIN_NONE,   0, 0, 0, 1, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    task automatic test_reset_in_return();
        logic [7:0] e, o; string t;
        apply("rr_half",       0, 1, COIN_HALF,   0, 0, 0, 0, E(2,0,0,0,0));
        apply("rr_dollar",     0, 1, COIN_DOLLAR, 0, 0, 0, 0, E(6,1,0,0,1));
        apply("rr_ack",        0, 0, COIN_NONE,   0, 0, 1, 0, E(3,0,1,0,1));
        apply("rr_chg2",       0, 0, COIN_NONE,   0, 0, 0, 1, E(2,0,1,0,1));
        apply("rr_reset",      1, 0, COIN_NONE,   0, 0, 0, 1, E(0,0,0,0,0));
        apply("rr_dollar2",    0, 1, COIN_DOLLAR, 0, 0, 0, 0, E(4,1,0,0,1));
        apply("rr_ack2",       0, 0, COIN_NONE,   0, 0, 1, 0, E(1,0,1,0,1));
        apply("rr_chg0",       0, 0, COIN_NONE,   0, 0, 0, 1, E(0,0,0,0,0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got {credit,dreq,creq,rej,busy}=%b required %b", t, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignores();
        test_quarters();
        test_back_to_back();
        test_sold_out_overflow();
        test_cancel();
        test_busy_ignores();
        test_reset_in_return();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
